dbus_arbiter: RTL

Two-master arbiter for the single AHB3-Lite data bus. It shares the bus between the core LSU (port 0, EX/MA load-store path) and an auxiliary master (port 1, debug/DMA). It sequences address and data phases, holds a delayed NONSEQ stable until accepted, and routes data-phase responses back to the owning requester. It sits between the LSU outputs and the data-bus pins.

---
 rtl/dbus_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_arbiter
//  Purpose  : Two-master arbiter for the AHB3-Lite data bus. Port 0 is the
//             core LSU, port 1 an auxiliary master (debug/DMA). Sequences
//             address and data phases, holds a stalled NONSEQ stable until
//             accepted and routes responses back to the owning requester.
//  Options  : DBUS_FAIRNESS_EN - when defined, port 1 gains one-shot
//             priority after waiting MAX_WAIT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic [1:0]  s_req_i,
  input  logic [31:0] s_addr_i [2],
  input  logic [1:0]  s_write_i,
  input  logic [1:0]  s_size_i [2],
  input  logic [31:0] s_wdata_i [2],
  output logic [1:0]  s_gnt_o,
  output logic [1:0]  s_rvalid_o,
  output logic [1:0]  s_rerr_o,
  output logic [31:0] s_rdata_o,
  output logic [31:0] s_haddr_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [1:0]  s_htrans_o,
  output logic [31:0] s_hwdata_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic [31:0] s_hrdata_i
);

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  // Elaboration-time guard on the wait threshold range.
  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("dbus_arbiter: MAX_WAIT must be in 1..255");
  end

  // State registers and their next-state values
  logic        lock_v_q,  lock_v_d;
  logic        lock_id_q, lock_id_d;
  logic        dp_v_q,    dp_v_d;
  logic        dp_id_q,   dp_id_d;
  logic [31:0] hwdata_q,  hwdata_d;

  // Combinational arbitration results
  logic w_err_first;
  logic w_src_v;
  logic w_src_id;
  logic w_accept;
  logic w_dp_done;
  logic w_p1_prio;

  // Select the address-phase source; the first ERROR cycle forces IDLE.
  always_comb begin
    w_err_first = dp_v_q & s_hresp_i & ~s_hready_i;
    w_src_v     = 1'b0;
    w_src_id    = 1'b0;
    if (!w_err_first) begin
      if (lock_v_q) begin
        w_src_v  = 1'b1;
        w_src_id = lock_id_q;
      end else if (w_p1_prio) begin
        w_src_v  = 1'b1;
        w_src_id = 1'b1;
      end else if (s_req_i[0]) begin
        w_src_v  = 1'b1;
        w_src_id = 1'b0;
      end else if (s_req_i[1]) begin
        w_src_v  = 1'b1;
        w_src_id = 1'b1;
      end
    end
  end

  assign w_accept  = w_src_v & s_hready_i;
  assign w_dp_done = dp_v_q & s_hready_i;

  // Address phase is driven straight from the selected requester.
  assign s_htrans_o = w_src_v ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
  assign s_haddr_o  = w_src_v ? s_addr_i[w_src_id] : 32'd0;
  assign s_hwrite_o = w_src_v ? s_write_i[w_src_id] : 1'b0;
  assign s_hsize_o  = w_src_v ? {1'b0, s_size_i[w_src_id]} : 3'd0;
  assign s_gnt_o    = {w_accept & w_src_id, w_accept & ~w_src_id};

  // Data-phase responses go to whoever owns the data phase.
  assign s_rvalid_o = {w_dp_done & dp_id_q, w_dp_done & ~dp_id_q};
  assign s_rerr_o   = {w_dp_done & dp_id_q & s_hresp_i,
                       w_dp_done & ~dp_id_q & s_hresp_i};
  assign s_rdata_o  = s_hrdata_i;
  assign s_hwdata_o = hwdata_q;

  // Next-state for the address lock, data-phase owner and write data.
  always_comb begin
    lock_v_d  = lock_v_q;
    lock_id_d = lock_id_q;
    if (w_err_first) begin
      lock_v_d = 1'b0;
    end else if (w_src_v && !s_hready_i) begin
      lock_v_d  = 1'b1;
      lock_id_d = w_src_id;
    end else if (w_accept) begin
      lock_v_d = 1'b0;
    end

    dp_v_d   = dp_v_q;
    dp_id_d  = dp_id_q;
    hwdata_d = hwdata_q;
    if (w_accept) begin
      dp_v_d   = 1'b1;
      dp_id_d  = w_src_id;
      hwdata_d = s_wdata_i[w_src_id];
    end else if (s_hready_i) begin
      dp_v_d = 1'b0;
    end
  end

  // Register the arbitration state; reset discards any pending transfer.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      lock_v_q  <= 1'b0;
      lock_id_q <= 1'b0;
      dp_v_q    <= 1'b0;
      dp_id_q   <= 1'b0;
      hwdata_q  <= 32'd0;
    end else begin
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      dp_v_q    <= dp_v_d;
      dp_id_q   <= dp_id_d;
      hwdata_q  <= hwdata_d;
    end
  end

`ifdef DBUS_FAIRNESS_EN
  localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       prio_q,     prio_d;

  // Count port-1 starvation; once saturated, arm one-shot priority.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    prio_d     = prio_q;
    if (w_accept && w_src_id) begin
      wait_cnt_d = 8'd0;
      prio_d     = 1'b0;
    end else if (s_req_i[1]) begin
      if (wait_cnt_q == c_MAX_WAIT) begin
        prio_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  // Register the fairness counter and priority flag.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      wait_cnt_q <= 8'd0;
      prio_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      prio_q     <= prio_d;
    end
  end

  assign w_p1_prio = prio_q & s_req_i[1];
`else
  assign w_p1_prio = 1'b0;
`endif

endmodule
`default_nettype wire
